// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor blocks: hash mode encodings,
// FSM states and the saturating-counter step function.
package branch_pkg;

  localparam int MODE_HIST   = 0;  // index = zero-extended history
  localparam int MODE_GSHARE = 1;  // index = PC bits XOR history

  // widest counter the step function supports
  localparam int CTR_MAX_W = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Next value of a w-bit saturating counter held in the low bits of ctr.
  // Saturates at 2^w-1 going up and at 0 going down.
  function automatic logic [CTR_MAX_W-1:0] sat_next(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int unsigned          w
  );
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << w) - 1);
    if (taken) return (ctr == top) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)  ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/branch_pht_2r1w.sv
// Pattern history table storage: two asynchronous read ports (lookup and
// update read-modify-write) and one synchronous write port. No reset; the
// owner is responsible for initialising the contents.
module branch_pht_2r1w #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int W     = 2
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_a_idx,
  output logic [W-1:0]  rd_a_data,
  input  logic [AW-1:0] rd_b_idx,
  output logic [W-1:0]  rd_b_data,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data
);

  logic [W-1:0] mem [DEPTH];

  // single write port; reads see the old value until the edge
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_a_data = mem[rd_a_idx];
  assign rd_b_data = mem[rd_b_idx];

endmodule

// File: rtl/branch_gshare.sv
// Gshare / global-history direction predictor. After reset the table is
// swept to weakly-not-taken one entry per cycle (busy=1), then the block
// serves combinational lookups and accepts one resolved update per cycle.
module branch_gshare
  import branch_pkg::*;
#(
  parameter int PHT_SIZE  = 2048,
  parameter int HIST_BITS = 11,
  parameter int CTR_BITS  = 2,
  parameter int MODE      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  input  logic [31:0]          PC,
  output logic                 prediction,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 update_en,
  input  logic                 update_val,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_hist
);

  localparam int IDX = $clog2(PHT_SIZE);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
  localparam logic [IDX-1:0] LAST_IDX = IDX'(PHT_SIZE - 1);

  state_e               state;
  logic [IDX-1:0]       init_ptr;
  logic [HIST_BITS-1:0] ghr, ghr_shift;
  logic [IDX-1:0]       look_idx, upd_idx, wr_idx;
  logic [CTR_BITS-1:0]  look_ctr, upd_ctr, wr_data;
  logic [CTR_MAX_W-1:0] upd_ext;
  logic                 we, upd_go;
  logic                 unused_ok;

  // index hash: same function for lookup and update sides
  if (MODE == MODE_GSHARE) begin : g_gshare
    assign look_idx = PC[IDX+1:2] ^ IDX'(ghr);
    assign upd_idx  = update_pc[IDX+1:2] ^ IDX'(update_hist);
  end else if (MODE == MODE_HIST) begin : g_hist
    assign look_idx = IDX'(ghr);
    assign upd_idx  = IDX'(update_hist);
  end else begin : g_hist_dflt
    assign look_idx = IDX'(ghr);
    assign upd_idx  = IDX'(update_hist);
  end

  // history shift; a 1-bit history simply holds the last outcome
  if (HIST_BITS == 1) begin : g_h1
    assign ghr_shift = update_val;
  end else begin : g_hn
    assign ghr_shift = {ghr[HIST_BITS-2:0], update_val};
  end

  assign upd_go  = (state == ST_RUN) && update_en;
  assign upd_ext = sat_next(CTR_MAX_W'(upd_ctr), update_val, CTR_BITS);

  // write-port arbitration: the init sweep owns the port while in INIT
  always_comb begin
    we      = 1'b0;
    wr_idx  = upd_idx;
    wr_data = CTR_BITS'(upd_ext);
    if (state == ST_INIT) begin
      we      = 1'b1;
      wr_idx  = init_ptr;
      wr_data = CTR_WNT;
    end else if (upd_go) begin
      we = 1'b1;
    end
  end

  branch_pht_2r1w #(
    .DEPTH (PHT_SIZE),
    .AW    (IDX),
    .W     (CTR_BITS)
  ) u_pht (
    .clk       (clk),
    .rd_a_idx  (look_idx),
    .rd_a_data (look_ctr),
    .rd_b_idx  (upd_idx),
    .rd_b_data (upd_ctr),
    .we        (we),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data)
  );

  // FSM: sweep the table once after reset, then run; history moves only in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      ghr      <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_IDX) state <= ST_RUN;
        end
        ST_RUN: begin
          if (update_en) ghr <= ghr_shift;
        end
      endcase
    end
  end

  assign busy       = (state == ST_INIT);
  assign prediction = (state == ST_RUN) & look_ctr[CTR_BITS-1];
  assign pred_hist  = ghr;

  // PC bits outside the index window and upper step-function bits are don't-care
  assign unused_ok = ^{PC, update_pc, upd_ext};

endmodule

// File: tb/tb_branch_gshare.sv
// Directed bench for branch_gshare (default parameters, gshare mode) with an
// array-based reference model checked against the outputs every cycle.
module tb_branch_gshare;

  localparam int PHT_SIZE  = 2048;
  localparam int HIST_BITS = 11;
  localparam int CTR_BITS  = 2;
  localparam int CTR_MAX   = (1 << CTR_BITS) - 1;
  localparam int MASK      = PHT_SIZE - 1;
  localparam int HMASK     = (1 << HIST_BITS) - 1;

  logic                 clk;
  logic                 reset;
  logic                 busy;
  logic [31:0]          PC;
  logic                 prediction;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 update_en;
  logic                 update_val;
  logic [31:0]          update_pc;
  logic [HIST_BITS-1:0] update_hist;

  int total = 0;
  int bad   = 0;

  branch_gshare #(
    .PHT_SIZE  (PHT_SIZE),
    .HIST_BITS (HIST_BITS),
    .CTR_BITS  (CTR_BITS),
    .MODE      (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .busy        (busy),
    .PC          (PC),
    .prediction  (prediction),
    .pred_hist   (pred_hist),
    .update_en   (update_en),
    .update_val  (update_val),
    .update_pc   (update_pc),
    .update_hist (update_hist)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int m_pht [PHT_SIZE];
  int m_ghr;
  int m_init;   // table entries still to be swept; >0 means busy
  bit chk_en = 1'b0;

  function automatic int idx_of(input logic [31:0] pc, input int hist);
    return ((pc >> 2) ^ hist) & MASK;
  endfunction

  function automatic int sat(input int v, input logic taken);
    if (taken) return (v + 1 > CTR_MAX) ? CTR_MAX : v + 1;
    return (v - 1 < 0) ? 0 : v - 1;
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ m_ghr) & MASK) << 2);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_init <= PHT_SIZE;
      m_ghr  <= 0;
    end else if (m_init > 0) begin
      m_pht[PHT_SIZE - m_init] <= (1 << (CTR_BITS - 1)) - 1;
      m_init <= m_init - 1;
    end else if (update_en) begin
      m_pht[idx_of(update_pc, int'(update_hist))] <=
        sat(m_pht[idx_of(update_pc, int'(update_hist))], update_val);
      m_ghr <= ((m_ghr << 1) | int'(update_val)) & HMASK;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_busy, exp_pred;
      exp_busy = (m_init > 0);
      exp_pred = exp_busy ? 1'b0 : 1'((m_pht[idx_of(PC, m_ghr)] >> (CTR_BITS - 1)) & 1);
      chk("model_busy", 32'(busy), 32'(exp_busy));
      chk("model_pred", 32'(prediction), 32'(exp_pred));
      chk("model_hist", 32'(pred_hist), 32'(m_ghr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic val, input logic [31:0] pc, input int n = 1);
    update_en   = 1'b1;
    update_val  = val;
    update_pc   = pc;
    update_hist = '0;
    tick(n);
    update_en   = 1'b0;
  endtask

  // counts busy cycles after reset release; returns at the first negedge with busy=0
  task automatic run_init(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic lookup(input string name, input int idx, input logic exp);
    PC = pc_for(idx);
    @(negedge clk);
    chk(name, 32'(prediction), 32'(exp));
    tick();
  endtask

  int cyc;

  initial begin
    reset = 1'b0; PC = '0;
    update_en = 1'b0; update_val = 1'b0; update_pc = '0; update_hist = '0;
    tick(2);
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pred", 32'(prediction), 32'd0);
    chk("rst_hist", 32'(pred_hist), 32'd0);
    tick();

    // release: INIT lasts exactly the table size
    reset = 1'b1;
    run_init(cyc);
    chk("init_len", 32'(cyc), 32'd2048);
    tick();
    for (int i = 0; i < 12; i++) begin
      PC = $urandom;
      tick();
    end
    PC = 32'h0000_1234;
    @(negedge clk);
    chk("post_init_pred", 32'(prediction), 32'd0);
    tick();

    // two taken updates to entry 0x40, then lookup via PC=0x10C with ghr=3
    upd(1'b1, 32'h100, 2);
    PC = 32'h10C;
    @(negedge clk);
    chk("train_pred", 32'(prediction), 32'd1);
    chk("train_hist", 32'(pred_hist), 32'h003);
    chk("model_e40", 32'(m_pht[12'h040]), 32'd3);
    tick();

    // saturation on entry 0x80
    upd(1'b1, 32'h200, 4);
    chk("sat_ghr", 32'(m_ghr), 32'h03F);
    lookup("sat_hi_pred", 12'h080, 1'b1);
    upd(1'b0, 32'h200, 4);
    @(negedge clk);
    chk("sat_lo_hist", 32'(pred_hist), 32'h3F0);
    tick();
    lookup("sat_lo_pred", 12'h080, 1'b0);
    upd(1'b0, 32'h200, 1);
    upd(1'b1, 32'h200, 1);
    lookup("sat_0to1_pred", 12'h080, 1'b0);
    upd(1'b1, 32'h200, 1);
    lookup("sat_1to2_pred", 12'h080, 1'b1);

    // same-cycle lookup and taken update on entry 0x100 (at 01)
    PC = pc_for(12'h100);
    update_en = 1'b1; update_val = 1'b1; update_pc = 32'h400; update_hist = '0;
    @(negedge clk);
    chk("bypass_now", 32'(prediction), 32'd0);
    tick();
    update_en = 1'b0;
    lookup("bypass_next", 12'h100, 1'b1);

    // reset mid-RUN with trained entries
    reset = 1'b0;
    @(negedge clk);
    chk("rrun_busy", 32'(busy), 32'd1);
    chk("rrun_hist", 32'(pred_hist), 32'd0);
    tick(3);
    reset = 1'b1;
    run_init(cyc);
    chk("rrun_init_len", 32'(cyc), 32'd2048);
    tick();
    lookup("rrun_e40", 12'h040, 1'b0);
    lookup("rrun_e80", 12'h080, 1'b0);
    upd(1'b1, 32'h100, 1);
    PC = 32'h104;  // (0x40 ^ ghr=1) << 2
    @(negedge clk);
    chk("rrun_e40_is01", 32'(prediction), 32'd1);
    tick();

    // updates held high through a reset interrupted mid-INIT
    reset = 1'b0;
    tick();
    update_en = 1'b1; update_val = 1'b1; update_pc = 32'h100; update_hist = '0;
    reset = 1'b1;
    tick(100);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run_init(cyc);
    update_en = 1'b0;
    chk("uinit_len", 32'(cyc), 32'd2048);
    chk("uinit_hist", 32'(pred_hist), 32'd0);
    tick();
    PC = 32'h100;
    @(negedge clk);
    chk("uinit_pred", 32'(prediction), 32'd0);
    tick();
    upd(1'b1, 32'h100, 1);
    PC = 32'h104;
    @(negedge clk);
    chk("uinit_is01", 32'(prediction), 32'd1);
    chk("uinit_hist1", 32'(pred_hist), 32'd1);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
